// File: rtl/distribute_1x2_one_hot_comb_pkg.sv
// Shared helpers for the one-hot distribution chain node.
// Sizes the command that is handed to the next chain stage.
package distribute_1x2_one_hot_comb_pkg;

  localparam int unsigned MIN_CMD_WIDTH = 32'd1;

  // The last stage still exposes a 1-bit o_cmd, tied low.
  function automatic int unsigned out_cmd_width(input int unsigned in_cmd_width);
    if (in_cmd_width <= MIN_CMD_WIDTH) begin
      out_cmd_width = MIN_CMD_WIDTH;
    end else begin
      out_cmd_width = in_cmd_width - 32'd1;
    end
  endfunction

endpackage

// File: rtl/distribute_1x2_one_hot_comb_core.sv
// Combinational routing core: forwards the word downstream, optionally to the
// local node, and strips the consumed command MSB.
module distribute_1x2_one_hot_comb_core
  import distribute_1x2_one_hot_comb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned IN_COMMAND_WIDTH = 2
) (
  input  logic                                       i_valid,
  input  logic [DATA_WIDTH-1:0]                      i_data_bus,
  input  logic                                       i_en,
  input  logic [IN_COMMAND_WIDTH-1:0]                i_cmd,
  output logic [1:0]                                 o_valid,
  output logic [2*DATA_WIDTH-1:0]                    o_data_bus,
  output logic [out_cmd_width(IN_COMMAND_WIDTH)-1:0] o_cmd
);

  logic w_act;

  assign w_act = i_en & i_valid;

  // Idle or disabled inputs must yield all-zero outputs whatever cmd/data hold.
  always_comb begin
    o_valid    = 2'b00;
    o_data_bus = '0;
    if (w_act) begin
      o_valid[0]                 = 1'b1;
      o_data_bus[DATA_WIDTH-1:0] = i_data_bus;
      if (i_cmd[IN_COMMAND_WIDTH-1]) begin
        o_valid[1]                            = 1'b1;
        o_data_bus[2*DATA_WIDTH-1:DATA_WIDTH] = i_data_bus;
      end else begin
        o_valid[1]                            = 1'b0;
        o_data_bus[2*DATA_WIDTH-1:DATA_WIDTH] = '0;
      end
    end else begin
      o_valid    = 2'b00;
      o_data_bus = '0;
    end
  end

  if (IN_COMMAND_WIDTH > 1) begin : g_cmd_strip
    // Pass the remaining command bits on only with a live word.
    always_comb begin
      o_cmd = '0;
      if (w_act) begin
        o_cmd = i_cmd[IN_COMMAND_WIDTH-2:0];
      end else begin
        o_cmd = '0;
      end
    end
  end else begin : g_cmd_last
    assign o_cmd = 1'b0;
  end

endmodule

// File: rtl/distribute_1x2_one_hot_comb.sv
// One node of the one-hot NoC distribution chain, with an optional
// single-cycle output register.
module distribute_1x2_one_hot_comb
  import distribute_1x2_one_hot_comb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned IN_COMMAND_WIDTH = 2,
  parameter int unsigned OUTPUT_REG       = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_valid,
  input  logic [DATA_WIDTH-1:0]                      i_data_bus,
  input  logic                                       i_en,
  input  logic [IN_COMMAND_WIDTH-1:0]                i_cmd,
  output logic [1:0]                                 o_valid,
  output logic [2*DATA_WIDTH-1:0]                    o_data_bus,
  output logic [out_cmd_width(IN_COMMAND_WIDTH)-1:0] o_cmd
);

  localparam int unsigned OUT_COMMAND_WIDTH = out_cmd_width(IN_COMMAND_WIDTH);

  logic [1:0]                   w_valid;
  logic [2*DATA_WIDTH-1:0]      w_data_bus;
  logic [OUT_COMMAND_WIDTH-1:0] w_cmd;

  distribute_1x2_one_hot_comb_core #(
    .DATA_WIDTH       (DATA_WIDTH),
    .IN_COMMAND_WIDTH (IN_COMMAND_WIDTH)
  ) u_core (
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_en       (i_en),
    .i_cmd      (i_cmd),
    .o_valid    (w_valid),
    .o_data_bus (w_data_bus),
    .o_cmd      (w_cmd)
  );

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic [1:0]                   r_valid;
    logic [2*DATA_WIDTH-1:0]      r_data_bus;
    logic [OUT_COMMAND_WIDTH-1:0] r_cmd;

    // Reset wins over capture so an in-flight word is dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid    <= 2'b00;
        r_data_bus <= '0;
        r_cmd      <= '0;
      end else begin
        r_valid    <= w_valid;
        r_data_bus <= w_data_bus;
        r_cmd      <= w_cmd;
      end
    end

    assign o_valid    = r_valid;
    assign o_data_bus = r_data_bus;
    assign o_cmd      = r_cmd;
  end else begin : g_out_comb
    assign o_valid    = w_valid;
    assign o_data_bus = w_data_bus;
    assign o_cmd      = w_cmd;
  end

endmodule

// File: tb/tb_distribute_1x2_one_hot_comb.sv
// Bench for the distribution node: combinational 2-bit and 1-bit command
// variants plus the registered variant, checked against a behavioural model.
module tb_distribute_1x2_one_hot_comb;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_en;
  logic [31:0] i_data;
  logic [1:0]  i_cmd2;
  logic [0:0]  i_cmd1;

  logic [1:0]  o_valid_a, o_valid_b, o_valid_c;
  logic [63:0] o_data_a,  o_data_b,  o_data_c;
  logic [0:0]  o_cmd_a,   o_cmd_b,   o_cmd_c;

  int total = 0;
  int bad   = 0;

  logic [66:0] exp_a, exp_b, exp_c;
  bit          c_known = 1'b0;

  always #5 clk = ~clk;

  distribute_1x2_one_hot_comb #(.DATA_WIDTH(32), .IN_COMMAND_WIDTH(2), .OUTPUT_REG(0)) u_a (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data), .i_en(i_en),
    .i_cmd(i_cmd2), .o_valid(o_valid_a), .o_data_bus(o_data_a), .o_cmd(o_cmd_a));

  distribute_1x2_one_hot_comb #(.DATA_WIDTH(32), .IN_COMMAND_WIDTH(1), .OUTPUT_REG(0)) u_b (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data), .i_en(i_en),
    .i_cmd(i_cmd1), .o_valid(o_valid_b), .o_data_bus(o_data_b), .o_cmd(o_cmd_b));

  distribute_1x2_one_hot_comb #(.DATA_WIDTH(32), .IN_COMMAND_WIDTH(2), .OUTPUT_REG(1)) u_c (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data), .i_en(i_en),
    .i_cmd(i_cmd2), .o_valid(o_valid_c), .o_data_bus(o_data_c), .o_cmd(o_cmd_c));

  // Reference: returns {valid[1:0], high[31:0], low[31:0], cmd_out}.
  function automatic logic [66:0] model(input bit en, input bit v, input logic [31:0] d,
                                        input int unsigned cmd, input int unsigned icw);
    bit          act;
    int unsigned msb, rest, nvalid;
    logic [31:0] hi, lo;
    act    = en && v;
    msb    = (cmd >> (icw - 1)) % 2;
    rest   = (icw > 1) ? cmd % (1 << (icw - 1)) : 0;
    nvalid = act ? (1 + 2 * msb) : 0;
    lo     = act ? d : 32'd0;
    hi     = (act && msb == 1) ? d : 32'd0;
    model  = {nvalid[1:0], hi, lo, (act ? rest[0] : 1'b0)};
  endfunction

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive on the falling edge, check combinational nodes, then the register after the edge.
  task automatic step(input string tag, input bit en, input bit v, input logic [31:0] d,
                      input logic [1:0] c2, input bit c1, input bit r);
    @(negedge clk);
    i_en = en; i_valid = v; i_data = d; i_cmd2 = c2; i_cmd1 = c1; rst = r;
    #1;
    if (c_known) chk({tag, "_reg_hold"}, {o_valid_c, o_data_c, o_cmd_c}, exp_c);
    exp_a = model(en, v, d, c2, 2);
    exp_b = model(en, v, d, c1, 1);
    chk({tag, "_comb2"}, {o_valid_a, o_data_a, o_cmd_a}, exp_a);
    chk({tag, "_comb1"}, {o_valid_b, o_data_b, o_cmd_b}, exp_b);
    @(posedge clk);
    #1;
    exp_c   = r ? 67'd0 : exp_a;
    c_known = 1'b1;
    chk({tag, "_reg"}, {o_valid_c, o_data_c, o_cmd_c}, exp_c);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rc;
    bit          ren, rv, rr;

    i_en = 1'b0; i_valid = 1'b0; i_data = 32'd0; i_cmd2 = 2'b00; i_cmd1 = 1'b0; rst = 1'b1;

    step("reset",      1'b0, 1'b0, 32'hAAAAAAAA, 2'b11, 1'b1, 1'b1);
    step("idle",       1'b0, 1'b0, 32'hAAAAAAAA, 2'b11, 1'b1, 1'b0);
    step("pass_only",  1'b1, 1'b1, 32'hAAAAAAAA, 2'b01, 1'b0, 1'b0);
    step("both",       1'b1, 1'b1, 32'hAAAAAAAA, 2'b11, 1'b1, 1'b0);
    step("both_new",   1'b1, 1'b1, 32'hBBBBBBBB, 2'b11, 1'b1, 1'b0);
    step("en_drop",    1'b0, 1'b1, 32'hBBBBBBBB, 2'b11, 1'b1, 1'b0);
    step("en_back",    1'b1, 1'b1, 32'hBBBBBBBB, 2'b11, 1'b1, 1'b0);
    step("valid_drop", 1'b1, 1'b0, 32'hBBBBBBBB, 2'b11, 1'b1, 1'b0);
    step("cmd10",      1'b1, 1'b1, 32'h12345678, 2'b10, 1'b0, 1'b0);
    step("rst_live",   1'b1, 1'b1, 32'hCAFEF00D, 2'b11, 1'b1, 1'b1);
    step("after_rst",  1'b1, 1'b1, 32'hCAFEF00D, 2'b11, 1'b1, 1'b0);
    step("all_ones",   1'b1, 1'b1, 32'hFFFFFFFF, 2'b01, 1'b1, 1'b0);
    step("x_free",     1'b0, 1'b1, 32'hFFFFFFFF, 2'b11, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rd  = $urandom;
      rc  = 2'($urandom_range(0, 3));
      ren = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 3) != 0);
      rr  = ($urandom_range(0, 9) == 0);
      step("rand", ren, rv, rd, rc, rc[0], rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
